// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH programmable clock dividers with shadowed config, per-channel enable and global phase sync
module clk_div_bank #(
  parameter int NCH          = 4,
  parameter int W            = 30,
  parameter int DIV_DEFAULT  = 50000000,
  parameter int HIGH_DEFAULT = 25000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  output logic [NCH-1:0] q,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);
  for (genvar g = 0; g < NCH; g++) begin : ch
    logic [W-1:0] cnt, div_act, high_act, div_sh, high_sh;
    logic [W-1:0] per, n_div, n_high, n_per, n_hi, n_cnt;
    logic         wrap, restart, apply, we, q_r, tick_r, pend_r;
    // q and tick are computed from the next count and next config so they stay aligned with cnt
    always_comb begin
      per     = div_act < W'(2) ? W'(2) : div_act;
      wrap    = cnt >= per - W'(1);
      restart = ~en[g] | sync | wrap;
      apply   = pend_r & restart;
      n_div   = apply ? div_sh : div_act;
      n_high  = apply ? high_sh : high_act;
      n_per   = n_div < W'(2) ? W'(2) : n_div;
      n_hi    = n_high > n_per ? n_per : n_high;
      n_cnt   = restart ? '0 : cnt + W'(1);
      we      = cfg_we && cfg_ch == 4'(g);
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt      <= '0;
        div_act  <= W'(DIV_DEFAULT);
        high_act <= W'(HIGH_DEFAULT);
        div_sh   <= W'(DIV_DEFAULT);
        high_sh  <= W'(HIGH_DEFAULT);
        pend_r   <= 1'b0;
        q_r      <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        cnt      <= n_cnt;
        div_act  <= n_div;
        high_act <= n_high;
        if (we) begin
          div_sh  <= cfg_div;
          high_sh <= cfg_high;
        end
        pend_r   <= we | (pend_r & ~apply);
        q_r      <= en[g] & (n_cnt >= n_per - n_hi);
        tick_r   <= en[g] & (n_cnt == '0);
      end
    end
    assign q[g]       = q_r;
    assign tick[g]    = tick_r;
    assign pending[g] = pend_r;
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and randomized checks of clk_div_bank against a period/phase reference model
module tb_clk_div_bank;
  localparam int NCH = 4;
  localparam int W = 30;
  localparam int DD = 10;
  localparam int HD = 5;
  logic clk = 0, reset = 0, sync = 0, cfg_we = 0;
  logic [NCH-1:0] en = '0;
  logic [3:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0, cfg_high = '0;
  logic [NCH-1:0] q, tick, pending;
  int checks = 0, failures = 0;
  int m_cnt[NCH], m_div[NCH], m_high[NCH], m_sdiv[NCH], m_shigh[NCH];
  bit m_pend[NCH], m_en[NCH];

  clk_div_bank #(.NCH(NCH), .W(W), .DIV_DEFAULT(DD), .HIGH_DEFAULT(HD)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .q(q), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int per_of(input int d);
    return d < 2 ? 2 : d;
  endfunction

  task automatic m_reset;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_div[i] = DD; m_high[i] = HD; m_sdiv[i] = DD; m_shigh[i] = HD;
      m_pend[i] = 0; m_en[i] = 0;
    end
  endtask

  // one clock of the reference: restart on disable/sync/end-of-period, pending shadow lands on restart
  task automatic m_edge;
    for (int i = 0; i < NCH; i++) begin
      bit restart, ap, we;
      restart = !en[i] || sync || (m_cnt[i] >= per_of(m_div[i]) - 1);
      ap = m_pend[i] && restart;
      we = cfg_we && (int'(cfg_ch) == i);
      if (ap) begin m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; end
      m_cnt[i] = restart ? 0 : m_cnt[i] + 1;
      if (we) begin m_sdiv[i] = int'(cfg_div); m_shigh[i] = int'(cfg_high); m_pend[i] = 1; end
      else if (ap) m_pend[i] = 0;
      m_en[i] = en[i];
    end
  endtask

  task automatic compare;
    logic [NCH-1:0] eq, et, ep;
    for (int i = 0; i < NCH; i++) begin
      int p, h;
      p = per_of(m_div[i]);
      h = m_high[i] > p ? p : m_high[i];
      eq[i] = m_en[i] && (m_cnt[i] >= p - h);
      et[i] = m_en[i] && (m_cnt[i] == 0);
      ep[i] = m_pend[i];
    end
    check("q", 32'(q), 32'(eq));
    check("tick", 32'(tick), 32'(et));
    check("pending", 32'(pending), 32'(ep));
  endtask

  task automatic step;
    @(posedge clk);
    if (!reset) m_edge();
    #1 compare();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int c, input int d, input int h);
    cfg_we = 1; cfg_ch = 4'(c); cfg_div = W'(d); cfg_high = W'(h);
    step();
    cfg_we = 0;
  endtask

  task automatic wait_cnt(input int c, input int v);
    bit found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_cnt[c] == v) found = 1;
      else step();
    end
    check("wait_cnt", 32'(found), 32'd1);
  endtask

  initial begin
    int first;
    m_reset();
    #1 reset = 1;
    run(2);
    check("rst_q", 32'(q), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    reset = 0; en = 4'hf;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (tick[0] && first == 0) first = k;
    end
    check("first_tick", 32'(first), 32'd10);
    run(5);
    // mid-period reprogram of ch1
    wait_cnt(1, 3);
    wr(1, 4, 1);
    check("ch1_pending", 32'(pending[1]), 32'd1);
    run(20);
    // clamped divisor and high >= period
    wr(2, 1, 0);
    wr(3, 6, 9);
    run(30);
    // write landing exactly on ch0's wrap edge
    wait_cnt(0, 9);
    wr(0, 7, 3);
    run(30);
    // enable drop and re-enable
    wait_cnt(0, 0);
    wr(0, 10, 5);
    run(12);
    wait_cnt(0, 7);
    en[0] = 0;
    run(3);
    check("dis_q", 32'(q[0]), 32'd0);
    en[0] = 1;
    run(22);
    // sync with an invalid-channel write and a pending shadow on ch1
    wait_cnt(1, 1);
    wr(1, 5, 2);
    sync = 1; cfg_we = 1; cfg_ch = 4'd9; cfg_div = W'(3); cfg_high = W'(1);
    step();
    sync = 0; cfg_we = 0;
    check("sync_tick", 32'(tick), 32'hf);
    check("sync_pending", 32'(pending), 32'd0);
    run(20);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      en = ($urandom % 10 == 0) ? NCH'($urandom) : 4'hf;
      sync = ($urandom % 23 == 0);
      cfg_we = ($urandom % 5 == 0);
      cfg_ch = 4'($urandom % 6);
      cfg_div = W'($urandom % 13);
      cfg_high = W'($urandom % 15);
      step();
    end
    en = 4'hf; sync = 0; cfg_we = 0;
    run(7);
    // asynchronous reset between edges
    #2 reset = 1;
    #1;
    check("arst_q", 32'(q), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    m_reset();
    run(2);
    reset = 0;
    run(25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
